mem2apb_bridge: RTL and testbench

MEM2APB_BRIDGE -- requirements
Module: mem2apb_bridge

---
 rtl/mem2apb_bridge.sv | 102 ++++++++++
 tb/tb_mem2apb_bridge.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem2apb_bridge.sv
// mem2apb_bridge: core-side req/gnt/rvalid memory port to APB master bridge with wait-state timeout
module mem2apb_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    input  logic [APB_ADDR_WIDTH-1:0]   addr_i,
    input  logic                        we_i,
    input  logic [APB_DATA_WIDTH/8-1:0] be_i,
    input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [APB_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
    output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
    output logic                        pwrite_o,
    output logic                        psel_o,
    output logic                        penable_o,
    input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
    input  logic                        pready_i,
    input  logic                        pslverr_i
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    // The last ACCESS cycle allowed to wait; the counter reaches TIMEOUT_CYCLES as it aborts.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;

    assign gnt_o = req_i && (state == IDLE || state == RESP);

    // Single FSM; every APB and response output is registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cnt       <= '0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
            rvalid_o  <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    psel_o    <= 1'b0;
                    penable_o <= 1'b0;
                    if (gnt_o) begin
                        paddr_o  <= addr_i;
                        pwrite_o <= we_i;
                        pwdata_o <= wdata_i;
                        if (we_i && !(&be_i)) begin
                            state    <= RESP;
                            rvalid_o <= 1'b1;
                            err_o    <= 1'b1;
                            rdata_o  <= '0;
                        end else begin
                            state  <= SETUP;
                            psel_o <= 1'b1;
                            cnt    <= '0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    penable_o <= 1'b1;
                end
                ACCESS: begin
                    if (pready_i) begin
                        state     <= RESP;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        rvalid_o  <= 1'b1;
                        err_o     <= pslverr_i;
                        rdata_o   <= pwrite_o ? '0 : prdata_i;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (cnt == TMO_LAST) begin
                            state     <= RESP;
                            psel_o    <= 1'b0;
                            penable_o <= 1'b0;
                            rvalid_o  <= 1'b1;
                            err_o     <= 1'b1;
                            rdata_o   <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem2apb_bridge.sv
// tb_mem2apb_bridge: table-driven, hand-sequenced and randomized checks of mem2apb_bridge
module tb_mem2apb_bridge;
    localparam int TMO = 8;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        req_i = 1'b0, we_i = 1'b0, pready_i = 1'b0, pslverr_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0, prdata_i = '0;
    logic [3:0]  be_i = '0;
    logic        gnt_o, rvalid_o, err_o, pwrite_o, psel_o, penable_o;
    logic [31:0] rdata_o, paddr_o, pwdata_o;
    int          checks = 0, errors = 0;

    always #5 clk_i = ~clk_i;

    mem2apb_bridge #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o),
        .pwrite_o(pwrite_o), .psel_o(psel_o), .penable_o(penable_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        int          lat;
        int          acc;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: outcome of one isolated transaction from the bridge's rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.we && v.be != 4'hF) begin
            r.lat = 1; r.acc = 0; r.err = 1'b1; r.rdata = '0;
        end else if (v.waits >= TMO) begin
            r.acc = TMO; r.lat = TMO + 2; r.err = 1'b1; r.rdata = '0;
        end else begin
            r.acc = v.waits + 1; r.lat = r.acc + 2; r.err = v.slverr; r.rdata = v.we ? '0 : v.prdata;
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        int c, acc, setup, bad;
        req_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata; be_i = v.be;
        prdata_i = v.prdata; pslverr_i = v.slverr; pready_i = 1'b0;
        #1 chk("gnt", 32'(gnt_o), 1);
        step();
        req_i = 1'b0; addr_i = $urandom; we_i = 1'($urandom); wdata_i = $urandom; be_i = 4'($urandom);
        acc = 0; setup = 0; bad = 0; c = 1;
        while (!rvalid_o && c < 300) begin
            if (psel_o) begin
                if (paddr_o !== v.addr || pwdata_o !== v.wdata || pwrite_o !== v.we) bad++;
                if (penable_o) acc++; else setup++;
            end
            pready_i = psel_o && penable_o && acc > v.waits;
            step();
            c++;
        end
        pready_i = 1'b0;
        chk("latency", 32'(c), 32'(v.lat));
        chk("rvalid", 32'(rvalid_o), 1);
        chk("err", 32'(err_o), 32'(v.err));
        chk("rdata", rdata_o, v.rdata);
        chk("access_cycles", 32'(acc), 32'(v.acc));
        chk("setup_cycles", 32'(setup), (v.acc > 0) ? 1 : 0);
        chk("apb_hold", 32'(bad), 0);
        chk("resp_psel", {30'b0, psel_o, penable_o}, 0);
        step();
        chk("rvalid_low", 32'(rvalid_o), 0);
        chk("err_hold", 32'(err_o), 32'(v.err));
        chk("rdata_hold", rdata_o, v.rdata);
    endtask

    initial begin
        int seen;
        vec_t v;
        vecs[0] = '{1'b0, 32'h1A10_0000, 32'h0,         4'hF, 0,  1'b0, 32'hCAFE_F00D, 3,  1, 1'b0, 32'hCAFE_F00D};
        vecs[1] = '{1'b1, 32'h1A10_1004, 32'h0000_00FF, 4'hF, 4,  1'b0, 32'hDEAD_BEEF, 7,  5, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 32'h1A10_2000, 32'h1234_5678, 4'h3, 0,  1'b0, 32'h5555_AAAA, 1,  0, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h1A10_3000, 32'h0,         4'hF, 20, 1'b0, 32'h7777_7777, 10, 8, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 32'h1A10_4000, 32'h0,         4'hF, 2,  1'b1, 32'h1234_5678, 5,  3, 1'b1, 32'h1234_5678};
        vecs[5] = '{1'b0, 32'h1A10_5000, 32'h0,         4'hF, 7,  1'b0, 32'h0BAD_CAFE, 10, 8, 1'b0, 32'h0BAD_CAFE};
        vecs[6] = '{1'b0, 32'h1A10_6000, 32'h0,         4'h1, 0,  1'b0, 32'hA5A5_5A5A, 3,  1, 1'b0, 32'hA5A5_5A5A};
        vecs[7] = '{1'b1, 32'h1A10_7000, 32'hFFFF_0000, 4'hF, 8,  1'b0, 32'h1111_2222, 10, 8, 1'b1, 32'h0};

        #12;
        chk("rst_apb_ctl", {29'b0, psel_o, penable_o, pwrite_o}, 0);
        chk("rst_paddr", paddr_o, 0);
        chk("rst_pwdata", pwdata_o, 0);
        chk("rst_resp", {30'b0, rvalid_o, err_o}, 0);
        chk("rst_rdata", rdata_o, 0);
        step();
        rst_ni = 1'b1;
        step();
        chk("idle_gnt_no_req", 32'(gnt_o), 0);
        chk("idle_psel", {30'b0, psel_o, penable_o}, 0);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Back-to-back: request held through the first response, first ends with a slave error.
        req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h2000_0010;
        prdata_i = 32'h1111_1111; pslverr_i = 1'b1; pready_i = 1'b0;
        #1 chk("b2b_gnt1", 32'(gnt_o), 1);
        step();
        addr_i = 32'h2000_0020;
        chk("b2b_setup1", {30'b0, psel_o, penable_o}, 2);
        chk("b2b_no_regrant", 32'(gnt_o), 0);
        pready_i = 1'b1;
        step();
        chk("b2b_access1", {30'b0, psel_o, penable_o}, 3);
        chk("b2b_paddr1", paddr_o, 32'h2000_0010);
        step();
        pready_i = 1'b0;
        chk("b2b_rvalid1", 32'(rvalid_o), 1);
        chk("b2b_err1", 32'(err_o), 1);
        chk("b2b_rdata1", rdata_o, 32'h1111_1111);
        chk("b2b_gnt_in_resp", 32'(gnt_o), 1);
        pslverr_i = 1'b0; prdata_i = 32'h2222_2222;
        step();
        req_i = 1'b0;
        chk("b2b_setup2", {30'b0, psel_o, penable_o}, 2);
        chk("b2b_paddr2", paddr_o, 32'h2000_0020);
        chk("b2b_rvalid_drop", 32'(rvalid_o), 0);
        pready_i = 1'b1;
        step();
        step();
        pready_i = 1'b0;
        chk("b2b_rvalid2", 32'(rvalid_o), 1);
        chk("b2b_err2", 32'(err_o), 0);
        chk("b2b_rdata2", rdata_o, 32'h2222_2222);
        step();

        // Reset pulsed mid-ACCESS: APB strobes drop before the next edge and no response follows.
        req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h3000_0000; pready_i = 1'b0;
        #1 chk("rst_txn_gnt", 32'(gnt_o), 1);
        step();
        req_i = 1'b0;
        step();
        step();
        chk("pre_rst_access", {30'b0, psel_o, penable_o}, 3);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_psel", {30'b0, psel_o, penable_o}, 0);
        chk("async_rst_paddr", paddr_o, 0);
        step();
        rst_ni = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rvalid_o || psel_o) seen++;
            step();
        end
        chk("no_resp_after_rst", 32'(seen), 0);
        run_txn(vecs[0]);

        for (int n = 0; n < 40; n++) begin
            v.we = 1'($urandom);
            v.addr = $urandom;
            v.wdata = $urandom;
            v.be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            v.waits = $urandom_range(0, 10);
            v.slverr = ($urandom_range(0, 3) == 0);
            v.prdata = $urandom;
            run_txn(model(v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
